// File: rtl/mem_access_unit.sv
// Load/store sequencer between the CPU memory stage and a single-port word RAM.
// Define MEM_ACCESS_RANGE_CHECK_EN to reject word addresses >= ADDR_LIMIT_WORDS.
module mem_access_unit #(
  parameter int ADDR_LIMIT_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        ram_wren,
  output logic [29:0] ram_address,
  output logic [31:0] ram_data,
  input  logic [31:0] ram_q
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    RMW_MERGE
  } state_t;

  localparam logic [29:0] LIMIT = 30'(ADDR_LIMIT_WORDS);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        accept;
  logic        misalign;
  logic        range_err;
  logic        req_err;
  logic        word_st;
  logic        wr;
  logic [31:0] wr_data;

  function automatic logic [31:0] extract(
    input logic [31:0] w,
    input logic [1:0]  off,
    input logic [1:0]  sz,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   extract = {{24{sgn & b[7]}}, b};
      2'b01:   extract = {{16{sgn & h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] w,
    input logic [1:0]  off,
    input logic [1:0]  sz,
    input logic [31:0] d
  );
    merge = w;
    case (sz)
      2'b00:   merge[{off, 3'b000} +: 8] = d[7:0];
      2'b01:   merge[{off[1], 4'b0000} +: 16] = d[15:0];
      default: merge = d;
    endcase
  endfunction

`ifdef MEM_ACCESS_RANGE_CHECK_EN
  assign range_err = (req_addr[31:2] >= LIMIT);
`else
  logic unused_limit;
  assign unused_limit = |LIMIT;
  assign range_err = 1'b0;
`endif

  always_comb begin
    case (req_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      default: misalign = 1'b1;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;
  assign req_err   = misalign | range_err;
  assign word_st   = req_we & (req_size == 2'b10);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      sgn_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    if (accept) begin
      addr_d  = req_addr;
      wdata_d = req_wdata;
      size_d  = req_size;
      sgn_d   = req_signed;
    end
    case (state_q)
      IDLE: begin
        if (accept && !req_err) begin
          if (!req_we)       state_d = LOAD_WAIT;
          else if (!word_st) state_d = RMW_MERGE;
        end
      end
      LOAD_WAIT: state_d = IDLE;
      RMW_MERGE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    wr           = 1'b0;
    wr_data      = '0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    ram_address  = addr_q[31:2];
    case (state_q)
      IDLE: begin
        ram_address = req_addr[31:2];
        if (accept) begin
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (word_st) begin
            wr           = 1'b1;
            wr_data      = req_wdata;
            resp_valid_d = 1'b1;
          end
        end
      end
      LOAD_WAIT: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = extract(ram_q, addr_q[1:0], size_q, sgn_q);
      end
      RMW_MERGE: begin
        wr           = 1'b1;
        wr_data      = merge(ram_q, addr_q[1:0], size_q, wdata_q);
        resp_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset must block any write, even a merge already in flight.
  assign ram_wren   = wr & rst_n;
  assign ram_data   = ram_wren ? wr_data : '0;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural word RAM.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        ram_wren;
  logic [29:0] ram_address;
  logic [31:0] ram_data;
  logic [31:0] ram_q = '0;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
    logic        chk;
  } exp_t;

  exp_t q[$];
  exp_t e;

  logic [31:0] mem [0:255];
  logic        unused_hi;
  assign unused_hi = ^ram_address[29:8];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata),
    .ram_wren(ram_wren), .ram_address(ram_address),
    .ram_data(ram_data), .ram_q(ram_q)
  );

  always @(posedge clk) begin
    if (ram_wren) mem[ram_address[7:0]] <= ram_data;
    ram_q <= mem[ram_address[7:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got resp_valid=1 want 0");
      end else begin
        e = q.pop_front();
        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        if (e.chk) chk("resp_rdata", resp_rdata, e.rd);
      end
    end
    if (!resp_valid && resp_err) begin
      total++;
      bad++;
      $display("FAIL err_unqualified: got resp_err=1 want 0");
    end
    if (!ram_wren && ram_data != 0) begin
      total++;
      bad++;
      $display("FAIL ram_data_idle: got %h want 0", ram_data);
    end
  end

  task automatic send(input logic we, input logic [1:0] sz,
                      input logic sgn, input logic [31:0] a,
                      input logic [31:0] wd, input logic push,
                      input logic e_err, input logic [31:0] e_rd,
                      input logic e_chk);
    int n;
    exp_t x;
    @(posedge clk);
    #1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = a;
    req_wdata  = wd;
    if (push) begin
      x.err = e_err;
      x.rd  = e_rd;
      x.chk = e_chk;
      q.push_back(x);
    end
  endtask

  task automatic accept();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic do_store(input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd);
    send(1'b1, sz, 1'b0, a, wd, 1'b1, 1'b0, 32'h0, 1'b0);
    accept();
  endtask

  task automatic do_load(input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] exp);
    send(1'b0, sz, sgn, a, 32'h0, 1'b1, 1'b0, exp, 1'b1);
    accept();
  endtask

  task automatic do_err(input logic we, input logic [1:0] sz,
                        input logic [31:0] a);
    send(we, sz, 1'b0, a, 32'h1234_5678, 1'b1, 1'b1, 32'h0, 1'b1);
    @(negedge clk);
    chk("err_no_wren", {31'b0, ram_wren}, 32'd0);
    accept();
    @(negedge clk);
    chk("err_valid", {31'b0, resp_valid}, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_wren", {31'b0, ram_wren}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("sw_wren", {31'b0, ram_wren}, 32'd1);
    chk("sw_addr", {2'b0, ram_address}, 32'd4);
    chk("sw_data", ram_data, 32'hDEAD_BEEF);
    accept();
    @(negedge clk);
    chk("sw_valid", {31'b0, resp_valid}, 32'd1);

    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
    accept();
    @(negedge clk);
    chk("lw_busy", {31'b0, req_ready}, 32'd0);
    chk("lw_early", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("lw_valid", {31'b0, resp_valid}, 32'd1);

    do_store(2'b10, 32'h10, 32'h1122_3344);
    send(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("sb_rd_wren", {31'b0, ram_wren}, 32'd0);
    chk("sb_rd_addr", {2'b0, ram_address}, 32'd4);
    accept();
    @(negedge clk);
    chk("sb_wr_wren", {31'b0, ram_wren}, 32'd1);
    chk("sb_wr_addr", {2'b0, ram_address}, 32'd4);
    chk("sb_wr_data", ram_data, 32'h11AA_3344);
    @(negedge clk);
    chk("sb_valid", {31'b0, resp_valid}, 32'd1);
    do_load(2'b10, 1'b0, 32'h10, 32'h11AA_3344);

    do_store(2'b10, 32'h10, 32'h80F0_7F01);
    do_load(2'b00, 1'b1, 32'h13, 32'hFFFF_FF80);
    do_load(2'b00, 1'b0, 32'h13, 32'h0000_0080);
    do_load(2'b01, 1'b1, 32'h10, 32'h0000_7F01);
    do_load(2'b01, 1'b1, 32'h12, 32'hFFFF_80F0);
    do_load(2'b01, 1'b0, 32'h12, 32'h0000_80F0);
    do_load(2'b00, 1'b0, 32'h11, 32'h0000_007F);
    do_load(2'b00, 1'b1, 32'h12, 32'hFFFF_FFF0);
    do_load(2'b00, 1'b1, 32'h10, 32'h0000_0001);

    do_err(1'b0, 2'b01, 32'h11);
    do_err(1'b1, 2'b10, 32'h12);
    do_err(1'b0, 2'b11, 32'h10);
`ifdef MEM_ACCESS_RANGE_CHECK_EN
    do_err(1'b0, 2'b10, 32'h400);
`endif

    do_store(2'b01, 32'h12, 32'h0000_BEEF);
    do_load(2'b10, 1'b0, 32'h10, 32'hBEEF_7F01);

    send(1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5_0001, 1'b1, 1'b0, 32'h0, 1'b0);
    send(1'b1, 2'b10, 1'b0, 32'h24, 32'hA5A5_0002, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("b2b_first_valid", {31'b0, resp_valid}, 32'd1);
    chk("b2b_wren", {31'b0, ram_wren}, 32'd1);
    accept();
    @(negedge clk);
    chk("b2b_second_valid", {31'b0, resp_valid}, 32'd1);
    do_load(2'b10, 1'b0, 32'h20, 32'hA5A5_0001);
    do_load(2'b10, 1'b0, 32'h24, 32'hA5A5_0002);

    send(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_0055, 1'b0, 1'b0, 32'h0, 1'b0);
    accept();
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_wren", {31'b0, ram_wren}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
    do_load(2'b10, 1'b0, 32'h10, 32'hBEEF_7F01);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the single-port word RAM interface: wren, 30-bit word address, 32-bit write data, and read data valid one cycle after the address.
- Accepts CPU load/store requests of byte, halfword or word size over a valid/ready handshake.
- Sequences RAM cycles, including a read-modify-write for sub-word stores.
- Returns extracted and extended load data or a completion pulse.
- Sits between the CPU execute/memory stage and the RAM; byte lanes are little-endian.

Parameters:
- ADDR_LIMIT_WORDS, 256, number of implemented RAM words; used only by the optional range check.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  request rejected; qualified by resp_valid.
- resp_rdata  out  32  load result; qualified by resp_valid and load.
- ram_wren  out  1  RAM write enable.
- ram_address  out  30  RAM word address.
- ram_data  out  32  RAM write data.
- ram_q  in  32  RAM read data; reflects the address presented on the previous cycle.

Behaviour:
- States:
  - IDLE
  - LOAD_WAIT
  - RMW_MERGE
- req_ready = (state == IDLE). Accept = req_valid & req_ready.
- In IDLE, ram_address = req_addr[31:2]. In other states it is the latched request address.
- Alignment error: halfword with addr[0] = 1, word with addr[1:0] != 0, or size 11.
  - No RAM write; state stays IDLE.
  - resp_valid = 1, resp_err = 1, resp_rdata = 0 on the next cycle.
- Word store, accepted cycle T:
  - ram_wren = 1 and ram_data = req_wdata combinationally in T.
  - State stays IDLE; resp_valid = 1 in T+1.
- Load, accepted T:
  - Latch addr[1:0], size and signed flag; go to LOAD_WAIT.
  - T+1: extract from ram_q, register the result, return to IDLE.
  - resp_valid and resp_rdata appear in T+2.
- Sub-word store, accepted T:
  - RAM read of the word in T; latch request; go to RMW_MERGE.
  - T+1: ram_wren = 1, ram_data = ram_q with the target lane(s) replaced by req_wdata[7:0] or [15:0]; return to IDLE.
  - resp_valid in T+2.
- Lane select:
  - byte lane k = addr[1:0], occupying bits 8k+7:8k;
  - halfword lane = addr[1], occupying bits 16h+15:16h.
- Extension:
  - req_signed = 1 replicates the top bit of the lane into bits 31 up.
  - req_signed = 0 zero-fills. Word loads pass through unchanged.
- resp_valid is a registered single-cycle pulse. A new request may be accepted in the same cycle resp_valid is high; back-to-back word stores give one response per cycle.
- Outputs outside the active cycles:
  - ram_wren = 0;
  - ram_data = 0 when ram_wren = 0;
  - resp_rdata holds its last value;
  - resp_err = 0 whenever resp_valid = 0.
- Reset (rst_n = 0 at posedge):
  - state = IDLE; resp_valid, resp_err, resp_rdata = 0.
  - ram_wren is gated by rst_n, so no write occurs while rst_n = 0, including an in-flight RMW_MERGE.
  - An aborted request produces no response.
- Simultaneous events: req_valid while not IDLE is ignored (req_ready = 0); the requester must hold its request.

Optional Feature:
- Macro: MEM_ACCESS_RANGE_CHECK_EN.
- When defined, a request with req_addr[31:2] >= ADDR_LIMIT_WORDS is treated exactly like an alignment error:
  - no RAM access;
  - resp_err = 1 with resp_valid on the next cycle.
- When undefined, the check is absent. Addresses are passed through and the RAM ignores the upper bits.

Test Plan:
- Reset, then word store addr 0x10 data 0xDEADBEEF -> ram_wren = 1, ram_address = 4 in the accept cycle; resp_valid = 1, resp_err = 0 one cycle later.
- Word load addr 0x10 -> resp_rdata = 0xDEADBEEF two cycles after accept; req_ready = 0 in the cycle in between.
- Preload word 4 = 0x11223344; byte store addr 0x12 data 0xAA -> second cycle writes 0x11AA3344 to address 4; resp_valid two cycles after accept.
- Preload word 4 = 0x80F07F01:
  - signed byte load at 0x13 -> 0xFFFFFF80;
  - unsigned byte load at 0x13 -> 0x00000080;
  - signed halfword load at 0x10 -> 0x00007F01;
  - signed halfword load at 0x12 -> 0xFFFF80F0.
- Halfword load at 0x11 and word store at 0x12 -> resp_err = 1, no ram_wren, resp_rdata = 0. With MEM_ACCESS_RANGE_CHECK_EN and default parameter, word load at 0x400 -> resp_err = 1.
- Sub-word store with rst_n driven low during RMW_MERGE -> ram_wren stays 0, word 4 unchanged, no resp_valid; after reset release req_ready = 1.
